// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared types and widths for the branch predict unit
package branch_predict_unit_pkg;
    localparam int PC_W = 16;
    typedef enum logic {BPU_BIMODAL = 1'b0, BPU_GSHARE = 1'b1} bpu_mode_t;
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: IF lookup, WB update and perf signals of the branch predict unit
interface branch_predict_unit_if #(parameter int HIST_W = 4);
    import branch_predict_unit_pkg::*;
    logic              lkp_en;
    logic [PC_W-1:0]   lkp_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid;
    logic              upd_cond;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_mispredict;
    logic [15:0]       perf_branches;
    logic [15:0]       perf_mispred;
    modport master (
        output lkp_en, lkp_pc, upd_valid, upd_cond, upd_pc, upd_taken, upd_target, upd_hist, upd_mispredict,
        input  pred_taken, pred_target, pred_hist, perf_branches, perf_mispred
    );
    modport slave (
        input  lkp_en, lkp_pc, upd_valid, upd_cond, upd_pc, upd_taken, upd_target, upd_hist, upd_mispredict,
        output pred_taken, pred_target, pred_hist, perf_branches, perf_mispred
    );
endinterface

// File: rtl/branch_predict_unit_sat_counter.sv
// sat_counter: one saturating increment/decrement step of a W-bit counter
module sat_counter #(parameter int W = 2) (
    input  logic [W-1:0] val,
    input  logic         up,
    output logic [W-1:0] nxt
);
    always_comb nxt = up ? (&val ? val : val + W'(1)) : (|val ? val - W'(1) : val);
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: tagged direct-mapped BTB plus saturating-counter PHT with
// bimodal/gshare indexing, speculative global history and perf counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int        HIST_W    = 4,
    parameter int        PHT_IDX_W = 5,
    parameter int        BTB_IDX_W = 4,
    parameter int        CTR_W     = 2,
    parameter int        CTR_INIT  = 1,
    parameter bpu_mode_t MODE      = BPU_GSHARE
) (
    input logic clk,
    input logic reset,
    branch_predict_unit_if.slave bus
);
    localparam int TAG_W = PC_W - 1 - BTB_IDX_W;
    typedef struct packed {
        logic             valid;
        logic             cond;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_entry_t;
    btb_entry_t        btb [2**BTB_IDX_W];
    logic [CTR_W-1:0]  pht [2**PHT_IDX_W];
    logic [HIST_W-1:0] ghr, ghr_next;
    logic [15:0]       perf_br, perf_mp, perf_br_nxt, perf_mp_nxt;
    logic [CTR_W-1:0]  lkp_ctr, upd_ctr, upd_ctr_nxt;
    logic [PHT_IDX_W-1:0] lkp_pht_idx, upd_pht_idx;
    btb_entry_t        lkp_entry;
    logic              lkp_hit;
    logic              unused_pc_lsb;

    function automatic logic [PHT_IDX_W-1:0] pht_index(logic [PC_W-1:0] pc, logic [HIST_W-1:0] h);
        return pc[PHT_IDX_W:1] ^ (MODE == BPU_GSHARE ? PHT_IDX_W'(h) : '0);
    endfunction

    function automatic logic [HIST_W-1:0] shift_in(logic [HIST_W-1:0] h, logic b);
        return HIST_W'({h, b});
    endfunction

    assign unused_pc_lsb = ^{bus.lkp_pc[0], bus.upd_pc[0]};
    assign lkp_pht_idx   = pht_index(bus.lkp_pc, ghr);
    assign upd_pht_idx   = pht_index(bus.upd_pc, bus.upd_hist);
    assign lkp_entry     = btb[bus.lkp_pc[BTB_IDX_W:1]];
    assign lkp_ctr       = pht[lkp_pht_idx];
    assign upd_ctr       = pht[upd_pht_idx];
    assign lkp_hit       = lkp_entry.valid && lkp_entry.tag == bus.lkp_pc[PC_W-1:BTB_IDX_W+1];

    assign bus.pred_taken    = lkp_hit && (!lkp_entry.cond || lkp_ctr[CTR_W-1]);
    assign bus.pred_target   = lkp_hit ? lkp_entry.target : '0;
    assign bus.pred_hist     = ghr;
    assign bus.perf_branches = perf_br;
    assign bus.perf_mispred  = perf_mp;

    // A WB repair wins over any speculative shift from the same cycle's lookup
    always_comb ghr_next = (bus.upd_valid && bus.upd_mispredict)
        ? (bus.upd_cond ? shift_in(bus.upd_hist, bus.upd_taken) : bus.upd_hist)
        : (bus.lkp_en && lkp_hit && lkp_entry.cond) ? shift_in(ghr, bus.pred_taken) : ghr;

    sat_counter #(.W(CTR_W)) u_pht_ctr (.val(upd_ctr), .up(bus.upd_taken), .nxt(upd_ctr_nxt));
    sat_counter #(.W(16))    u_perf_br (.val(perf_br), .up(1'b1),          .nxt(perf_br_nxt));
    sat_counter #(.W(16))    u_perf_mp (.val(perf_mp), .up(1'b1),          .nxt(perf_mp_nxt));

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr     <= '0;
            perf_br <= '0;
            perf_mp <= '0;
            for (int i = 0; i < 2**BTB_IDX_W; i++) btb[i] <= '0;
            for (int i = 0; i < 2**PHT_IDX_W; i++) pht[i] <= CTR_W'(CTR_INIT);
        end else begin
            ghr <= ghr_next;
            if (bus.upd_valid && bus.upd_cond) pht[upd_pht_idx] <= upd_ctr_nxt;
            if (bus.upd_valid && bus.upd_taken)
                btb[bus.upd_pc[BTB_IDX_W:1]] <= '{valid: 1'b1, cond: bus.upd_cond,
                    tag: bus.upd_pc[PC_W-1:BTB_IDX_W+1], target: bus.upd_target};
            if (bus.upd_valid) perf_br <= perf_br_nxt;
            if (bus.upd_valid && bus.upd_mispredict) perf_mp <= perf_mp_nxt;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed stimulus with a table-level reference model checked every cycle
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;
    localparam int HW = 4, PW = 5, BW = 4, CW = 2, CI = 1;
    localparam int BD = 1 << BW, PD = 1 << PW, HMASK = (1 << HW) - 1, CMAX = (1 << CW) - 1;

    logic clk = 0;
    logic reset;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.HIST_W(HW)) bus ();
    branch_predict_unit #(.HIST_W(HW), .PHT_IDX_W(PW), .BTB_IDX_W(BW), .CTR_W(CW), .CTR_INIT(CI),
        .MODE(BPU_GSHARE)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, failures = 0;
    bit armed = 0;
    int m_pht [PD];
    bit m_valid [BD];
    bit m_cond [BD];
    int m_tag [BD];
    int m_tgt [BD];
    int m_ghr, m_br, m_mp;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gshare prediction straight from the model tables
    function automatic void predict(input int pc, output bit t, output int tgt, output bit hit_cond);
        int bi = (pc >> 1) % BD;
        int pi = ((pc >> 1) % PD) ^ m_ghr;
        bit hit = m_valid[bi] && m_tag[bi] == (pc >> (BW + 1));
        t = hit && (!m_cond[bi] || m_pht[pi] > CMAX / 2);
        tgt = hit ? m_tgt[bi] : 0;
        hit_cond = hit && m_cond[bi];
    endfunction

    always @(posedge clk) begin
        bit pt, hc;
        int ptg, pi, bi, c;
        if (reset) begin
            for (int i = 0; i < PD; i++) m_pht[i] <= CI;
            for (int i = 0; i < BD; i++) m_valid[i] <= 0;
            m_ghr <= 0;
            m_br <= 0;
            m_mp <= 0;
            armed <= 1;
        end else begin
            predict(int'(bus.lkp_pc), pt, ptg, hc);
            if (bus.upd_valid && bus.upd_mispredict)
                m_ghr <= bus.upd_cond ? ((int'(bus.upd_hist) * 2 + int'(bus.upd_taken)) & HMASK) : int'(bus.upd_hist);
            else if (bus.lkp_en && hc)
                m_ghr <= (m_ghr * 2 + int'(pt)) & HMASK;
            if (bus.upd_valid && bus.upd_cond) begin
                pi = ((int'(bus.upd_pc) >> 1) % PD) ^ int'(bus.upd_hist);
                c = m_pht[pi] + (bus.upd_taken ? 1 : -1);
                m_pht[pi] <= c > CMAX ? CMAX : (c < 0 ? 0 : c);
            end
            if (bus.upd_valid && bus.upd_taken) begin
                bi = (int'(bus.upd_pc) >> 1) % BD;
                m_valid[bi] <= 1;
                m_cond[bi] <= bus.upd_cond;
                m_tag[bi] <= int'(bus.upd_pc) >> (BW + 1);
                m_tgt[bi] <= int'(bus.upd_target);
            end
            if (bus.upd_valid && m_br < 65535) m_br <= m_br + 1;
            if (bus.upd_valid && bus.upd_mispredict && m_mp < 65535) m_mp <= m_mp + 1;
        end
    end

    always @(negedge clk) begin
        bit pt, hc;
        int ptg;
        if (armed && !reset) begin
            predict(int'(bus.lkp_pc), pt, ptg, hc);
            chk("m_pred_taken", bus.pred_taken, int'(pt));
            chk("m_pred_target", bus.pred_target, ptg);
            chk("m_pred_hist", bus.pred_hist, m_ghr);
            chk("m_perf_branches", bus.perf_branches, m_br);
            chk("m_perf_mispred", bus.perf_mispred, m_mp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input bit cond, input int pc, input bit taken, input int tgt, input int hist, input bit misp);
        bus.upd_valid = 1;
        bus.upd_cond = cond;
        bus.upd_pc = 16'(pc);
        bus.upd_taken = taken;
        bus.upd_target = 16'(tgt);
        bus.upd_hist = HW'(hist);
        bus.upd_mispredict = misp;
        step();
        bus.upd_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        bus.lkp_en = 0; bus.lkp_pc = 0; bus.upd_valid = 0; bus.upd_cond = 0; bus.upd_pc = 0;
        bus.upd_taken = 0; bus.upd_target = 0; bus.upd_hist = 0; bus.upd_mispredict = 0;
        reset = 1;
        step();
        step();
        reset = 0;
        // 1: reset state
        bus.lkp_pc = 16'h0010;
        @(negedge clk);
        chk("t1_taken", bus.pred_taken, 0);
        chk("t1_target", bus.pred_target, 0);
        chk("t1_hist", bus.pred_hist, 0);
        // 2: two taken updates push the counter 1->3
        step();
        upd(1, 'h0010, 1, 'h0040, 0, 0);
        upd(1, 'h0010, 1, 'h0040, 0, 0);
        @(negedge clk);
        chk("t2_taken", bus.pred_taken, 1);
        chk("t2_target", bus.pred_target, 'h0040);
        // 3: 0x0030 aliases 0x0010 in the BTB and evicts it
        step();
        upd(1, 'h0030, 1, 'h0080, 0, 0);
        @(negedge clk);
        chk("t3_miss_taken", bus.pred_taken, 0);
        chk("t3_miss_target", bus.pred_target, 0);
        step();
        bus.lkp_pc = 16'h0030;
        @(negedge clk);
        chk("t3_hit_taken", bus.pred_taken, 1);
        chk("t3_hit_target", bus.pred_target, 'h0080);
        // 4: speculative history then same-cycle repair
        step();
        do_reset();
        upd(1, 'h0010, 1, 'h0040, 0, 0);
        upd(1, 'h0010, 1, 'h0040, 0, 0);
        upd(1, 'h0010, 1, 'h0040, 1, 0);
        upd(1, 'h0010, 1, 'h0040, 1, 0);
        bus.lkp_pc = 16'h0010;
        bus.lkp_en = 1;
        @(negedge clk);
        chk("t4_spec0_taken", bus.pred_taken, 1);
        chk("t4_spec0_hist", bus.pred_hist, 0);
        step();
        @(negedge clk);
        chk("t4_spec1_taken", bus.pred_taken, 1);
        chk("t4_spec1_hist", bus.pred_hist, 1);
        step();
        bus.upd_valid = 1; bus.upd_cond = 1; bus.upd_pc = 16'h0100; bus.upd_taken = 0;
        bus.upd_target = 0; bus.upd_hist = 4'b0001; bus.upd_mispredict = 1;
        @(negedge clk);
        chk("t4_spec2_hist", bus.pred_hist, 'b0011);
        step();
        bus.upd_valid = 0;
        bus.lkp_en = 0;
        @(negedge clk);
        chk("t4_recover_hist", bus.pred_hist, 'b0010);
        // 5: gshare separates history 0000 and 0011 for one pc
        step();
        do_reset();
        upd(1, 'h0020, 1, 'h0060, 0, 0);
        upd(1, 'h0020, 1, 'h0060, 0, 0);
        upd(1, 'h0020, 0, 'h0060, 3, 0);
        upd(1, 'h0020, 0, 'h0060, 3, 0);
        bus.lkp_pc = 16'h0020;
        @(negedge clk);
        chk("t5_h0_taken", bus.pred_taken, 1);
        chk("t5_h0_target", bus.pred_target, 'h0060);
        step();
        upd(0, 'h0200, 0, 0, 3, 1);
        @(negedge clk);
        chk("t5_h3_hist", bus.pred_hist, 'b0011);
        chk("t5_h3_taken", bus.pred_taken, 0);
        // 6: perf counters saturate, then reset mid-stream clears everything
        step();
        bus.upd_valid = 1; bus.upd_cond = 0; bus.upd_pc = 16'h0200; bus.upd_taken = 0;
        bus.upd_target = 0; bus.upd_hist = 0; bus.upd_mispredict = 1;
        repeat (65540) step();
        @(negedge clk);
        chk("t6_perf_mispred_sat", bus.perf_mispred, 'hFFFF);
        chk("t6_perf_branches_sat", bus.perf_branches, 'hFFFF);
        step();
        do_reset();
        bus.upd_valid = 0;
        bus.upd_mispredict = 0;
        @(negedge clk);
        chk("t6_rst_perf_branches", bus.perf_branches, 0);
        chk("t6_rst_perf_mispred", bus.perf_mispred, 0);
        chk("t6_rst_taken", bus.pred_taken, 0);
        chk("t6_rst_target", bus.pred_target, 0);
        chk("t6_rst_hist", bus.pred_hist, 0);
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
